emu_scan_ctrl: RTL
==================

// Module: emu_scan_ctrl
// PURPOSE
//  Host-side driver for a halt-transformed DUT's checkpoint port: generates HALT, FF/RAM SCAN, RAM DIR, SDI.
//  SAVE streams FF then RAM chain words out (non-destructive: SDO rotated back into SDI).
//  LOAD streams host words into FF then RAM chains.
//  Sits between the platform command/stream interface and the emulated DUT's scan pins.
// PARAMETERS
//  DW        64  scan word width (matches DUT SDI/SDO)
//  FF_WORDS  16  FF chain length in DW words; 0 = no FF chain
//  RAM_WORDS 64  RAM chain length in DW words; 0 = no RAM chain
//  CW        16  word counter width; must hold max(FF_WORDS,RAM_WORDS)
// PORTS
//  clk        in   1   single clock, shared with DUT
//  rst_n      in   1   asynchronous reset, active-low
//  cmd_valid  in   1   command handshake
//  cmd_ready  out  1   high only in IDLE
//  cmd_op     in   2   0 SAVE, 1 LOAD, 2 RESUME, 3 HALT
//  in_valid   in   1   LOAD data stream valid
//  in_ready   out  1   LOAD data stream ready
//  in_data    in   DW  LOAD word
//  out_valid  out  1   SAVE data stream valid
//  out_ready  in   1   SAVE data stream ready
//  out_data   out  DW  SAVE word
//  done       out  1   1-cycle pulse at end of SAVE/LOAD
//  halt       out  1   to DUT HALT
//  ff_scan    out  1   to DUT FF SCAN
//  ff_sdi     out  DW  to DUT FF SDI
//  ff_sdo     in   DW  from DUT FF SDO
//  ram_scan   out  1   to DUT RAM SCAN
//  ram_dir    out  1   to DUT RAM DIR: 0 save (read out), 1 load (write in)
//  ram_sdi    out  DW  to DUT RAM SDI
//  ram_sdo    in   DW  from DUT RAM SDO
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE; halt=0, done=0, ff_scan=0, ram_scan=0, ram_dir=0, counters 0.
//  Reset mid-operation aborts immediately; halt drops to 0; chain contents undefined.
//  Chain model: head word on *_sdo; each posedge with *_scan=1 shifts one word, *_sdi enters the tail.
//  States: IDLE, PREP, FF, RAM, DONE.
//  IDLE: cmd_ready=1; cmd fire (valid&ready):
//   - HALT: halt<=1.
//   - RESUME: halt<=0.
//   - SAVE/LOAD: halt<=1; latch op; go to PREP.
//  PREP (1 cycle; DUT settles halted; no scan):
//   - load counter with FF_WORDS; go to FF.
//   - If FF_WORDS=0: load RAM_WORDS, go to RAM.
//   - If both 0: go to DONE.
//  FF state:
//   - SAVE: out_valid=1, out_data=ff_sdo, ff_sdi=ff_sdo, ff_scan=out_ready.
//   - LOAD: in_ready=1, ff_sdi=in_data, ff_scan=in_valid.
//   - Counter decrements on each scan cycle. Last word (counter==1) scanned: load RAM_WORDS, go to RAM (or DONE if 0).
//  RAM state: same rules using ram_*; ram_dir=op (held for whole state); ram_scan only in RAM.
//  DONE: done=1 for one cycle; halt stays 1; return to IDLE.
//  Handshake rules:
//   - *_scan is combinational from the stream handshake, so no word is lost or duplicated under backpressure.
//   - out_data is stable while out_valid & !out_ready.
//  Outside FF/RAM: out_valid=0, in_ready=0, both scans 0, sdi=0.
//  Command restrictions: commands other than in IDLE are not accepted. HALT while halted and RESUME while running are no-ops.
//  Latency: SAVE/LOAD with no stalls = 1 (IDLE fire) + 1 (PREP) + FF_WORDS + RAM_WORDS + 1 (DONE) cycles.
//  ff_scan and ram_scan are never 1 together; neither is ever 1 while halt=0.
// STRUCTURE
//  Package emu_scan_pkg: op codes (OP_SAVE/LOAD/RESUME/HALT), state enum, DIR encodings.
//  Sub-module emu_scan_cnt: loadable down-counter with 'last' flag, width CW.
//  Top holds FSM, halt flag and stream/scan muxing.
// TESTING
//  Bench uses a behavioural DW-wide shift-register chain model per chain; FF_WORDS=4, RAM_WORDS=8.
//  1 Reset then HALT, RESUME -> halt 0->1->0; cmd_ready stays 1; no scan pulses.
//  2 Preload FF model 0x10..0x13, RAM model 0x20..0x27; SAVE, out_ready=1
//    -> out_data 0x10..0x13,0x20..0x27 in order; done 14 cycles after cmd fire; chains unchanged; halt=1.
//  3 SAVE with out_ready toggling at random 50%
//    -> identical 12-word sequence; no scan pulse on cycles with out_ready=0.
//  4 LOAD words 0xA0..0xAB with random in_valid gaps
//    -> FF model holds 0xA0..0xA3, RAM model 0xA4..0xAB; ram_dir=1 throughout RAM state.
//  5 rst_n low during the 3rd RAM word of a SAVE
//    -> halt, scans, done, out_valid all 0 immediately; cmd_ready=1 after release.
//  6 Build with FF_WORDS=0 and a SAVE
//    -> no ff_scan; 8 RAM words out; done 10 cycles after fire.

Source files
------------

// File: rtl/emu_scan_pkg.sv
// Shared definitions for the checkpoint scan controller.
//   op_e    : host command codes carried on cmd_op
//   state_e : controller FSM states
//   DIR_*   : encodings driven on ram_dir
package emu_scan_pkg;

   typedef enum logic [1:0] {
      OP_SAVE   = 2'd0,
      OP_LOAD   = 2'd1,
      OP_RESUME = 2'd2,
      OP_HALT   = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_FF,
      ST_RAM,
      ST_DONE
   } state_e;

   // RAM chain direction: read words out of the DUT memories, or write them in
   localparam logic DIR_SAVE = 1'b0;
   localparam logic DIR_LOAD = 1'b1;

endpackage

// File: rtl/emu_scan_cnt.sv
// Loadable down-counter tracking the words remaining in the current chain.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : new word count
//   dec        : decrement by one (one word scanned)
//   last       : count is 1, i.e. the word being scanned now is the final one
module emu_scan_cnt #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic          last
);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign last = (count_reg == CW'(1));

endmodule

// File: rtl/emu_scan_ctrl.sv
// Host-side checkpoint driver for a halt-transformed DUT.
// SAVE streams the FF chain then the RAM chain out on out_*, feeding each
// word back into the chain tail so the DUT state is preserved. LOAD streams
// in_* words into the FF chain then the RAM chain.
//   clk, rst_n          : clock shared with the DUT, async active-low reset
//   cmd_valid/ready/op  : command handshake (accepted only in IDLE)
//   in_valid/ready/data : LOAD word stream
//   out_valid/ready/data: SAVE word stream
//   done                : one-cycle pulse when SAVE/LOAD completes
//   halt                : DUT HALT
//   ff_scan/sdi/sdo     : DUT FF chain pins
//   ram_scan/dir/sdi/sdo: DUT RAM chain pins
module emu_scan_ctrl
   import emu_scan_pkg::*;
#(
   parameter int DW        = 64,
   parameter int FF_WORDS  = 16,
   parameter int RAM_WORDS = 64,
   parameter int CW        = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          done,
   output logic          halt,
   output logic          ff_scan,
   output logic [DW-1:0] ff_sdi,
   input  logic [DW-1:0] ff_sdo,
   output logic          ram_scan,
   output logic          ram_dir,
   output logic [DW-1:0] ram_sdi,
   input  logic [DW-1:0] ram_sdo
);

   localparam logic [CW-1:0] FF_LEN  = CW'(FF_WORDS);
   localparam logic [CW-1:0] RAM_LEN = CW'(RAM_WORDS);

   state_e        state_reg;
   op_e           op_reg;
   logic          halt_reg;
   logic          done_reg;

   logic          in_ff;
   logic          in_ram;
   logic          is_save;
   logic          cnt_load;
   logic [CW-1:0] cnt_val;
   logic          cnt_last;

   assign in_ff   = (state_reg == ST_FF);
   assign in_ram  = (state_reg == ST_RAM);
   assign is_save = (op_reg == OP_SAVE);

   assign cmd_ready = (state_reg == ST_IDLE);
   assign halt      = halt_reg;
   assign done      = done_reg;
   assign ram_dir   = (in_ram && op_reg == OP_LOAD) ? DIR_LOAD : DIR_SAVE;

   // Scan enables follow the stream handshake combinationally: a chain only
   // shifts on the exact cycle a word is transferred, so backpressure can
   // neither drop nor repeat a word. While stalled the chain head (and thus
   // out_data) holds still.
   always_comb begin
      out_valid = 1'b0;
      in_ready  = 1'b0;
      out_data  = '0;
      ff_scan   = 1'b0;
      ff_sdi    = '0;
      ram_scan  = 1'b0;
      ram_sdi   = '0;
      if (in_ff) begin
         if (is_save) begin
            out_valid = 1'b1;
            out_data  = ff_sdo;
            ff_sdi    = ff_sdo;
            ff_scan   = out_ready;
         end else begin
            in_ready  = 1'b1;
            ff_sdi    = in_data;
            ff_scan   = in_valid;
         end
      end else if (in_ram) begin
         if (is_save) begin
            out_valid = 1'b1;
            out_data  = ram_sdo;
            ram_sdi   = ram_sdo;
            ram_scan  = out_ready;
         end else begin
            in_ready  = 1'b1;
            ram_sdi   = in_data;
            ram_scan  = in_valid;
         end
      end
   end

   // Counter is reloaded in PREP and again when the FF chain's last word goes
   // out, so the RAM phase starts with a fresh count.
   assign cnt_load = (state_reg == ST_PREP) || (in_ff && ff_scan && cnt_last);
   assign cnt_val  = (state_reg == ST_PREP && FF_WORDS != 0) ? FF_LEN : RAM_LEN;

   emu_scan_cnt #(
      .CW(CW)
   ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (cnt_load),
      .load_val(cnt_val),
      .dec     (ff_scan | ram_scan),
      .last    (cnt_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         op_reg    <= OP_SAVE;
         halt_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (cmd_valid) begin
                  case (op_e'(cmd_op))
                     OP_HALT:   halt_reg <= 1'b1;
                     OP_RESUME: halt_reg <= 1'b0;
                     default: begin
                        halt_reg  <= 1'b1;
                        op_reg    <= op_e'(cmd_op);
                        state_reg <= ST_PREP;
                     end
                  endcase
               end
            end
            // One idle cycle so the DUT is settled in halt before any shift
            ST_PREP: begin
               if (FF_WORDS != 0) begin
                  state_reg <= ST_FF;
               end else if (RAM_WORDS != 0) begin
                  state_reg <= ST_RAM;
               end else begin
                  state_reg <= ST_DONE;
                  done_reg  <= 1'b1;
               end
            end
            ST_FF: begin
               if (ff_scan && cnt_last) begin
                  if (RAM_WORDS != 0) begin
                     state_reg <= ST_RAM;
                  end else begin
                     state_reg <= ST_DONE;
                     done_reg  <= 1'b1;
                  end
               end
            end
            ST_RAM: begin
               if (ram_scan && cnt_last) begin
                  state_reg <= ST_DONE;
                  done_reg  <= 1'b1;
               end
            end
            default: begin
               // DONE: halt stays asserted until an explicit RESUME
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
